// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: shares the register file write port among NUM_REQ
// writers (optional fixed-priority requester, otherwise round-robin).
module regfile_write_arbiter #(
   parameter int NUM_REQ  = 3,
   parameter int PRIO_REQ = NUM_REQ,
   parameter int DATA_W   = 8,
   parameter int ADDR_W   = 2
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      hold,
   input  logic [NUM_REQ-1:0]        req_valid,
   input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
   input  logic [NUM_REQ*DATA_W-1:0] req_data,
   output logic [NUM_REQ-1:0]        req_ready,
   output logic                      rf_write_enable,
   output logic [ADDR_W-1:0]         rf_write_addr,
   output logic [DATA_W-1:0]         rf_write_data,
   output logic [2**ADDR_W-1:0]      pending_mask
);
   localparam int PTR_W    = $clog2(NUM_REQ);
   localparam bit PRIO_EN  = PRIO_REQ < NUM_REQ;
   localparam int PRIO_IDX = PRIO_EN ? PRIO_REQ : 0;
   localparam logic [PTR_W-1:0] LAST = PTR_W'(NUM_REQ - 1);

   typedef struct packed {
      logic              valid;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } stage_t;

   logic [ADDR_W-1:0] addr_a [NUM_REQ];
   logic [DATA_W-1:0] data_a [NUM_REQ];
   logic [PTR_W-1:0]  rr_ptr, rr_next, win_idx, hi_idx, lo_idx;
   logic              hit_hi, hit_lo, prio_hit;
   logic              any_grant, rr_grant;
   stage_t            stage_q, stage_d;

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
      assign addr_a[g] = req_addr[g*ADDR_W +: ADDR_W];
      assign data_a[g] = req_data[g*DATA_W +: DATA_W];
   end

   // hi: first valid at or above rr_ptr; lo: first valid overall (wrap)
   always_comb begin
      hit_hi = 1'b0;
      hit_lo = 1'b0;
      hi_idx = '0;
      lo_idx = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (req_valid[i]) begin
            hit_lo = 1'b1;
            lo_idx = PTR_W'(i);
         end
         if (req_valid[i] && (PTR_W'(i) >= rr_ptr)) begin
            hit_hi = 1'b1;
            hi_idx = PTR_W'(i);
         end
      end
   end

   always_comb begin
      prio_hit  = PRIO_EN && req_valid[PRIO_IDX];
      any_grant = 1'b0;
      rr_grant  = 1'b0;
      win_idx   = '0;
      if (!reset && !hold) begin
         if (prio_hit) begin
            any_grant = 1'b1;
            win_idx   = PTR_W'(PRIO_IDX);
         end else if (hit_lo) begin
            any_grant = 1'b1;
            rr_grant  = 1'b1;
            win_idx   = hit_hi ? hi_idx : lo_idx;
         end
      end
   end

   assign rr_next = (win_idx == LAST) ? '0 : win_idx + PTR_W'(1);

   always_comb begin
      req_ready = '0;
      if (any_grant)
         req_ready[win_idx] = 1'b1;
   end

   always_comb begin
      stage_d       = stage_q;
      stage_d.valid = any_grant;
      if (any_grant) begin
         stage_d.addr = addr_a[win_idx];
         stage_d.data = data_a[win_idx];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         stage_q <= '0;
         rr_ptr  <= '0;
      end else begin
         stage_q <= stage_d;
         if (rr_grant)
            rr_ptr <= rr_next;
      end
   end

   assign rf_write_enable = stage_q.valid;
   assign rf_write_addr   = stage_q.addr;
   assign rf_write_data   = stage_q.data;

   always_comb begin
      pending_mask = '0;
      if (stage_q.valid)
         pending_mask[stage_q.addr] = 1'b1;
      for (int i = 0; i < NUM_REQ; i++)
         if (req_valid[i])
            pending_mask[addr_a[i]] = 1'b1;
   end
endmodule
